// File: rtl/axi_lite_master_ctrl_if.sv
// AXI-Lite bus bundle between axi_lite_master_ctrl (master) and a control-register slave.
interface axi_lite_master_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic              wvalid;
   logic              wready;
   logic              bvalid;
   logic [1:0]        bresp;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI-Lite master turning a cmd/rsp port into AXI-Lite reads and writes.
// Optional watchdog (sticky timeout_err) is built when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module axi_lite_master_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [ADDR_W-1:0]      cmd_addr,
   input  logic [DATA_W-1:0]      cmd_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic [1:0]             rsp_resp,
   output logic                   rsp_write,
   axi_lite_master_ctrl_if.master m_axi,
   output logic                   timeout_err
);
   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;
   logic              aw_done, w_done;

   // A channel counts as done once its VALID has dropped or is being accepted this cycle.
   assign aw_done = !awvalid_q || m_axi.awready;
   assign w_done  = !wvalid_q || m_axi.wready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_ADDR;
               end
            end
         end
         WR: begin
            if (m_axi.awready) awvalid_d = 1'b0;
            if (m_axi.wready)  wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (m_axi.bvalid) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = m_axi.bresp;
               rsp_rdata_d = '0;
               rsp_write_d = 1'b1;
               state_d     = RSP;
            end
         end
         RD_ADDR: begin
            if (m_axi.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_axi.rvalid) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = m_axi.rresp;
               rsp_rdata_d = m_axi.rdata;
               rsp_write_d = 1'b0;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign cmd_ready     = (state_q == IDLE);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_write     = rsp_write_q;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYC);

   logic [31:0] tmo_cnt_q, tmo_cnt_d;
   logic        timeout_err_q, timeout_err_d;
   logic        waiting;

   // The flag only reports a stuck slave; the FSM keeps waiting since VALID may not be withdrawn.
   always_comb begin
      waiting       = (state_q != IDLE) && (state_q != RSP);
      tmo_cnt_d     = tmo_cnt_q;
      timeout_err_d = timeout_err_q;
      if (state_q == IDLE) begin
         tmo_cnt_d = '0;
      end else if (waiting && (tmo_cnt_q != '1)) begin
         tmo_cnt_d = tmo_cnt_q + 32'd1;
      end
      if (waiting && (TMO_LIM != 32'd0) && (tmo_cnt_d >= TMO_LIM)) timeout_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   logic unused_tmo;
   assign unused_tmo  = (TIMEOUT_CYC != 0);
   assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Bench for axi_lite_master_ctrl: register-file slave with configurable delays, vector table,
// corner-case sequences and random traffic against a register-map reference model.
module tb_axi_lite_master_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_write;
   logic        timeout_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   axi_lite_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi_lite_master_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write),
      .m_axi(bus), .timeout_err(timeout_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- slave: 5 registers at 0x00..0x10, anything else answers SLVERR
   logic [31:0] sreg [5];
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   bit          rbv = 0, ar_hang = 0;
   bit          have_aw, have_w, have_ar, b_pend;
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   int          b_hs_n = 0, proto_err = 0;
   bit          w_first_seen = 0;
   logic        p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
   logic [31:0] p_awaddr, p_wdata, p_araddr;

   function automatic bit addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a < 32'h14);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         sreg[0] = '0; sreg[1] = 32'h1; sreg[2] = '0; sreg[3] = '0; sreg[4] = '0;
         have_aw = 0; have_w = 0; have_ar = 0; b_pend = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
         p_awaddr = '0; p_wdata = '0; p_araddr = '0;
         bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
         bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
      end else begin
         // pending VALIDs/READYs from the master must hold (with stable payload) until accepted
         if (p_awvalid && !bus.awready && (!bus.awvalid || bus.awaddr != p_awaddr)) proto_err++;
         if (p_wvalid && !bus.wready && (!bus.wvalid || bus.wdata != p_wdata)) proto_err++;
         if (p_arvalid && !bus.arready && (!bus.arvalid || bus.araddr != p_araddr)) proto_err++;
         if (p_bready && !bus.bvalid && !bus.bready) proto_err++;
         if (p_rready && !bus.rvalid && !bus.rready) proto_err++;
         if (bus.awvalid && !bus.wvalid) w_first_seen = 1;

         if (p_awvalid && bus.awready) begin have_aw = 1; s_awaddr = p_awaddr; end
         if (p_wvalid && bus.wready) begin have_w = 1; s_wdata = p_wdata; end
         if (p_bready && bus.bvalid) begin bus.bvalid = 0; b_hs_n++; end
         if (p_arvalid && bus.arready) begin have_ar = 1; s_araddr = p_araddr; r_cnt = 0; end
         if (p_rready && bus.rvalid) bus.rvalid = 0;

         if (have_aw && have_w) begin
            if (addr_ok(s_awaddr)) begin
               sreg[s_awaddr[4:2]] = s_wdata;
               bus.bresp = 2'b00;
            end else begin
               bus.bresp = 2'b10;
            end
            have_aw = 0; have_w = 0; b_pend = 1; b_cnt = 0;
         end
         if (b_pend) begin
            if (b_cnt >= b_dly) begin bus.bvalid = 1; b_pend = 0; end
            else b_cnt++;
         end
         if (have_ar) begin
            if (r_cnt >= r_dly) begin
               bus.rvalid = 1;
               bus.rresp  = addr_ok(s_araddr) ? 2'b00 : 2'b10;
               bus.rdata  = addr_ok(s_araddr) ? sreg[s_araddr[4:2]] : 32'h0;
               have_ar    = 0;
            end else r_cnt++;
         end

         bus.awready = !have_aw && (rbv || (bus.awvalid && aw_cnt >= aw_dly));
         aw_cnt      = (bus.awvalid && !have_aw) ? aw_cnt + 1 : 0;
         bus.wready  = !have_w && (rbv || (bus.wvalid && w_cnt >= w_dly));
         w_cnt       = (bus.wvalid && !have_w) ? w_cnt + 1 : 0;
         bus.arready = !have_ar && !bus.rvalid && !ar_hang && (rbv || (bus.arvalid && ar_cnt >= ar_dly));
         ar_cnt      = (bus.arvalid && !have_ar) ? ar_cnt + 1 : 0;

         p_awvalid = bus.awvalid; p_wvalid = bus.wvalid; p_bready = bus.bready;
         p_arvalid = bus.arvalid; p_rready = bus.rready;
         p_awaddr  = bus.awaddr;  p_wdata  = bus.wdata;  p_araddr = bus.araddr;
      end
   end

   // ---------------- reference model: the register map seen through the master
   logic [31:0] ref_regs [5];

   task automatic ref_init();
      ref_regs[0] = '0; ref_regs[1] = 32'h1; ref_regs[2] = '0; ref_regs[3] = '0; ref_regs[4] = '0;
   endtask

   task automatic ref_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output logic [1:0] er, output logic [31:0] ed);
      bit ok;
      ok = (a % 4 == 0) && (a < 20);
      er = ok ? 2'b00 : 2'b10;
      ed = '0;
      if (ok) begin
         if (wr) ref_regs[a / 4] = d;
         else    ed = ref_regs[a / 4];
      end
   endtask

   // ---------------- host-side helpers
   task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
      aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; cmd_valid = 0; rsp_ready = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      ref_init();
   endtask

   task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
      int t;
      t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      chk("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      @(posedge clk); #1;
      cmd_valid = 0;
      if (wr) chk("aw_w_valid_lat1", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b110);
      else    chk("ar_valid_lat1", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b001);
   endtask

   task automatic take_rsp(output logic [1:0] resp, output logic [31:0] rd, output logic rw);
      int t;
      t = 0;
      @(negedge clk);
      while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
      chk("rsp_valid_wait", rsp_valid, 1);
      resp = rsp_resp; rd = rsp_rdata; rw = rsp_write;
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      chk("rsp_done_cmd_ready", {rsp_valid, cmd_ready}, 2'b01);
   endtask

   task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [1:0] resp, output logic [31:0] rd, output logic rw);
      issue(wr, a, d);
      take_rsp(resp, rd, rw);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          aw_d, w_d, b_d, ar_d, r_d;
      logic [1:0]  eresp;
      logic [31:0] erdata;
   } vec_t;

   vec_t        vecs [9];
   logic [31:0] addr_pool [9];

   initial begin
      logic [1:0]  g_resp, e_resp;
      logic [31:0] g_rd, e_rd;
      logic        g_rw;
      int          b_before;

      vecs[0] = '{1'b1, 32'h08, 32'h10,   0, 0, 0, 0, 0, 2'b00, 32'h0};
      vecs[1] = '{1'b1, 32'h0C, 32'h20,   3, 0, 0, 0, 0, 2'b00, 32'h0};
      vecs[2] = '{1'b0, 32'h04, 32'h0,    0, 0, 0, 0, 5, 2'b00, 32'h1};
      vecs[3] = '{1'b0, 32'h08, 32'h0,    0, 0, 0, 0, 0, 2'b00, 32'h10};
      vecs[4] = '{1'b1, 32'h20, 32'h99,   0, 0, 0, 0, 0, 2'b10, 32'h0};
      vecs[5] = '{1'b0, 32'h40, 32'h0,    0, 0, 0, 0, 0, 2'b10, 32'h0};
      vecs[6] = '{1'b1, 32'h10, 32'hABCD, 0, 2, 3, 0, 0, 2'b00, 32'h0};
      vecs[7] = '{1'b0, 32'h0C, 32'h0,    0, 0, 0, 0, 0, 2'b00, 32'h20};
      vecs[8] = '{1'b0, 32'h10, 32'h0,    0, 0, 0, 2, 1, 2'b00, 32'hABCD};
      addr_pool = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20, 32'h40, 32'h02};

      do_reset();
      @(negedge clk);
      chk("reset_ctrl", {cmd_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.bready,
                         bus.arvalid, bus.rready, rsp_write, timeout_err}, 9'b1_0000_0000);
      chk("reset_data", {rsp_rdata, rsp_resp}, 34'h0);
      chk("reset_addr", {bus.awaddr, bus.wdata}, 64'h0);

      for (int i = 0; i < 9; i++) begin
         set_dly(vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d, vecs[i].ar_d, vecs[i].r_d);
         do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, g_resp, g_rd, g_rw);
         chk($sformatf("vec%0d_resp", i), g_resp, vecs[i].eresp);
         chk($sformatf("vec%0d_rdata", i), g_rd, vecs[i].erdata);
         chk($sformatf("vec%0d_rsp_write", i), g_rw, vecs[i].wr);
      end
      chk("slave_reg08", sreg[2], 32'h10);

      // W accepted first, AW three cycles later: one B, one response
      set_dly(3, 0, 0, 0, 0);
      w_first_seen = 0;
      b_before = b_hs_n;
      do_cmd(1'b1, 32'h00, 32'h55, g_resp, g_rd, g_rw);
      chk("skew_w_dropped_first", w_first_seen, 1);
      chk("skew_resp", {g_resp, g_rw}, 3'b001);
      repeat (4) @(negedge clk);
      chk("skew_one_b", b_hs_n - b_before, 1);
      chk("skew_no_extra_rsp", rsp_valid, 0);

      // response held off for 4 cycles while the next command is already offered
      set_dly(0, 0, 0, 0, 0);
      issue(1'b0, 32'h08, 32'h0);
      begin
         int t;
         t = 0;
         @(negedge clk);
         while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
      end
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0C; cmd_wdata = 32'h77;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d", k), {rsp_valid, rsp_rdata, rsp_resp, rsp_write, cmd_ready, bus.awvalid},
             {1'b1, 32'h10, 2'b00, 1'b0, 1'b0, 1'b0});
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      chk("bp_release", {rsp_valid, cmd_ready, bus.awvalid}, 3'b010);
      @(posedge clk); #1;
      cmd_valid = 0;
      chk("bp_next_accept", {cmd_ready, bus.awvalid, bus.wvalid}, 3'b011);
      take_rsp(g_resp, g_rd, g_rw);
      chk("bp_next_rsp", {g_resp, g_rw}, 3'b001);

      // reset while AW is stalled
      set_dly(1000, 0, 0, 0, 0);
      issue(1'b1, 32'h04, 32'h1234);
      repeat (3) @(negedge clk);
      do_reset();
      #1;
      chk("midrst_state", {cmd_ready, bus.awvalid, bus.wvalid, bus.bready, rsp_valid}, 5'b10000);
      set_dly(0, 0, 0, 0, 0);
      do_cmd(1'b0, 32'h04, 32'h0, g_resp, g_rd, g_rw);
      chk("midrst_read_status", {g_resp, g_rd}, {2'b00, 32'h1});

      // random traffic, with and without ready-before-valid
      for (int n = 0; n < 40; n++) begin
         bit          wr;
         logic [31:0] a, d;
         wr  = 1'($urandom_range(0, 1));
         a   = addr_pool[$urandom_range(0, 8)];
         d   = $urandom;
         rbv = 1'($urandom_range(0, 1));
         set_dly($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 4));
         ref_access(wr, a, d, e_resp, e_rd);
         do_cmd(wr, a, d, g_resp, g_rd, g_rw);
         chk($sformatf("rnd%0d_a%0h_w%0d", n, a, wr), {g_resp, g_rd, g_rw}, {e_resp, e_rd, wr});
      end
      rbv = 0;
      set_dly(0, 0, 0, 0, 0);
      chk("protocol_hold", proto_err, 0);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      ar_hang = 1;
      issue(1'b0, 32'h04, 32'h0);
      repeat (15) @(posedge clk);
      #1;
      chk("tmo_before_16", timeout_err, 0);
      @(posedge clk); #1;
      chk("tmo_at_16", {timeout_err, bus.arvalid}, 2'b11);
      repeat (5) @(posedge clk);
      #1;
      chk("tmo_sticky", {timeout_err, bus.arvalid}, 2'b11);
      ar_hang = 0;
      do_reset();
      #1;
      chk("tmo_rst_clear", {cmd_ready, timeout_err, bus.arvalid}, 3'b100);
`else
      chk("timeout_err_tied", timeout_err, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
